// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, control-sequencer state encoding
// and opcode classification helpers.
package cpu_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [OPW-1:0] OP_HALT = 5'b11011;

    localparam int STW = 4;

    localparam logic [STW-1:0] S_RESET = 4'd0;
    localparam logic [STW-1:0] S_T0    = 4'd1;
    localparam logic [STW-1:0] S_T1    = 4'd2;
    localparam logic [STW-1:0] S_T2    = 4'd3;
    localparam logic [STW-1:0] S_T3    = 4'd4;
    localparam logic [STW-1:0] S_T4    = 4'd5;
    localparam logic [STW-1:0] S_T5    = 4'd6;
    localparam logic [STW-1:0] S_T6    = 4'd7;
    localparam logic [STW-1:0] S_HALT  = 4'd8;
    localparam logic [STW-1:0] S_FAULT = 4'd9;

    typedef enum logic [STW-1:0] {
        ST_RESET = S_RESET,
        ST_T0    = S_T0,
        ST_T1    = S_T1,
        ST_T2    = S_T2,
        ST_T3    = S_T3,
        ST_T4    = S_T4,
        ST_T5    = S_T5,
        ST_T6    = S_T6,
        ST_HALT  = S_HALT,
        ST_FAULT = S_FAULT
    } state_t;

    // Register-format ALU ops: operands Rb, Rc; result written back to Ra.
    function automatic logic is_alu_op(input logic [OPW-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

    // Mul/div: operands Ra, Rb; 64-bit result lands in HI/LO.
    function automatic logic is_muldiv_op(input logic [OPW-1:0] op);
        return (op == OP_DIV) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath: opcode and memory
// handshake in, bus-drive enables, register strobes and status out.
interface control_sequencer_if;
    import cpu_pkg::*;

    logic [OPW-1:0] ir_opcode;
    logic           mem_ready;

    logic           PCout;
    logic           Zhighout;
    logic           Zlowout;
    logic           MDRout;
    logic           Rout;

    logic           Gra;
    logic           Grb;
    logic           Grc;

    logic           Rin;
    logic           MARin;
    logic           PCin;
    logic           MDRin;
    logic           IRin;
    logic           Yin;
    logic           Zin;
    logic           HIin;
    logic           LOin;

    logic           IncPC;
    logic           Read;
    logic [OPW-1:0] alu_op;
    logic           run;
    logic           mem_fault;

    modport master (
        input  ir_opcode, mem_ready,
        output PCout, Zhighout, Zlowout, MDRout, Rout,
        output Gra, Grb, Grc,
        output Rin, MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, alu_op, run, mem_fault
    );

    modport slave (
        output ir_opcode, mem_ready,
        input  PCout, Zhighout, Zlowout, MDRout, Rout,
        input  Gra, Grb, Grc,
        input  Rin, MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, alu_op, run, mem_fault
    );

endinterface

// File: rtl/control_sequencer.sv
// Moore control FSM feeding the datapath bus mux: fetch with a bounded
// memory-ready wait, then execute for ALU, mul/div, nop and halt.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int TW          = 4
) (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   wait_cnt;
    logic [TW-1:0]   wait_cnt_next;
    logic            op_alu;
    logic            op_muldiv;

    assign op_alu    = is_alu_op(bus.ir_opcode);
    assign op_muldiv = is_muldiv_op(bus.ir_opcode);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= ST_RESET;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = '0;

        bus.PCout     = 1'b0;
        bus.Zhighout  = 1'b0;
        bus.Zlowout   = 1'b0;
        bus.MDRout    = 1'b0;
        bus.Rout      = 1'b0;
        bus.Gra       = 1'b0;
        bus.Grb       = 1'b0;
        bus.Grc       = 1'b0;
        bus.Rin       = 1'b0;
        bus.MARin     = 1'b0;
        bus.PCin      = 1'b0;
        bus.MDRin     = 1'b0;
        bus.IRin      = 1'b0;
        bus.Yin       = 1'b0;
        bus.Zin       = 1'b0;
        bus.HIin      = 1'b0;
        bus.LOin      = 1'b0;
        bus.IncPC     = 1'b0;
        bus.Read      = 1'b0;
        bus.alu_op    = '0;
        bus.run       = 1'b1;
        bus.mem_fault = 1'b0;

        case (state)
            ST_RESET: begin
                state_next = ST_T0;
            end

            ST_T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zin    = 1'b1;
                bus.alu_op = OP_ADD;
                state_next = ST_T1;
            end

            // Zlow keeps PC+1 for the whole wait; PC is loaded once, on entry.
            ST_T1: begin
                bus.Zlowout = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                bus.PCin    = (wait_cnt == '0);
                if (bus.mem_ready) begin
                    state_next = ST_T2;
                end else if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
                    state_next = ST_FAULT;
                end else begin
                    state_next    = ST_T1;
                    wait_cnt_next = wait_cnt + TW'(1);
                end
            end

            ST_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                if (bus.ir_opcode == OP_HALT) begin
                    state_next = ST_HALT;
                end else if (bus.ir_opcode == OP_NOP) begin
                    state_next = ST_T0;
                end else if (op_alu || op_muldiv) begin
                    state_next = ST_T3;
                end else begin
                    state_next = ST_T0;
                end
            end

            ST_T3: begin
                if (op_alu) begin
                    bus.Grb    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Yin    = 1'b1;
                    state_next = ST_T4;
                end else if (op_muldiv) begin
                    bus.Gra    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Yin    = 1'b1;
                    state_next = ST_T4;
                end else begin
                    state_next = ST_T0;
                end
            end

            ST_T4: begin
                if (op_alu) begin
                    bus.Grc    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Zin    = 1'b1;
                    bus.alu_op = bus.ir_opcode;
                    state_next = ST_T5;
                end else if (op_muldiv) begin
                    bus.Grb    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Zin    = 1'b1;
                    bus.alu_op = bus.ir_opcode;
                    state_next = ST_T5;
                end else begin
                    state_next = ST_T0;
                end
            end

            ST_T5: begin
                if (op_alu) begin
                    bus.Zlowout = 1'b1;
                    bus.Gra     = 1'b1;
                    bus.Rin     = 1'b1;
                    state_next  = ST_T0;
                end else if (op_muldiv) begin
                    bus.Zlowout = 1'b1;
                    bus.LOin    = 1'b1;
                    state_next  = ST_T6;
                end else begin
                    state_next = ST_T0;
                end
            end

            ST_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                state_next   = ST_T0;
            end

            ST_HALT: begin
                bus.run    = 1'b0;
                state_next = ST_HALT;
            end

            ST_FAULT: begin
                bus.run       = 1'b0;
                bus.mem_fault = 1'b1;
                state_next    = ST_FAULT;
            end

            default: begin
                state_next = ST_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected per-cycle control words are
// queued with the stimulus and compared on each falling clock edge.
module tb_control_sequencer;
    import cpu_pkg::*;

    logic clock = 1'b0;
    logic clear;

    control_sequencer_if bus();

    control_sequencer dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [25:0] word;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [25:0] PCOUT  = 26'd1 << 25;
    localparam logic [25:0] ZHIGH  = 26'd1 << 24;
    localparam logic [25:0] ZLOW   = 26'd1 << 23;
    localparam logic [25:0] MDROUT = 26'd1 << 22;
    localparam logic [25:0] ROUT   = 26'd1 << 21;
    localparam logic [25:0] GRA    = 26'd1 << 20;
    localparam logic [25:0] GRB    = 26'd1 << 19;
    localparam logic [25:0] GRC    = 26'd1 << 18;
    localparam logic [25:0] RIN    = 26'd1 << 17;
    localparam logic [25:0] MARIN  = 26'd1 << 16;
    localparam logic [25:0] PCIN   = 26'd1 << 15;
    localparam logic [25:0] MDRIN  = 26'd1 << 14;
    localparam logic [25:0] IRIN   = 26'd1 << 13;
    localparam logic [25:0] YIN    = 26'd1 << 12;
    localparam logic [25:0] ZIN    = 26'd1 << 11;
    localparam logic [25:0] HIIN   = 26'd1 << 10;
    localparam logic [25:0] LOIN   = 26'd1 << 9;
    localparam logic [25:0] INCPC  = 26'd1 << 8;
    localparam logic [25:0] READ   = 26'd1 << 7;
    localparam logic [25:0] RUN    = 26'd1 << 6;
    localparam logic [25:0] MFLT   = 26'd1 << 5;

    localparam logic [25:0] W_RESET = RUN;
    localparam logic [25:0] W_T0    = RUN | PCOUT | MARIN | INCPC | ZIN | 26'b00011;
    localparam logic [25:0] W_T1F   = RUN | ZLOW | PCIN | READ | MDRIN;
    localparam logic [25:0] W_T1W   = RUN | ZLOW | READ | MDRIN;
    localparam logic [25:0] W_T2    = RUN | MDROUT | IRIN;
    localparam logic [25:0] W_A3    = RUN | GRB | ROUT | YIN;
    localparam logic [25:0] W_A4    = RUN | GRC | ROUT | ZIN;
    localparam logic [25:0] W_A5    = RUN | ZLOW | GRA | RIN;
    localparam logic [25:0] W_M3    = RUN | GRA | ROUT | YIN;
    localparam logic [25:0] W_M4    = RUN | GRB | ROUT | ZIN;
    localparam logic [25:0] W_M5    = RUN | ZLOW | LOIN;
    localparam logic [25:0] W_M6    = RUN | ZHIGH | HIIN;
    localparam logic [25:0] W_HALT  = 26'd0;
    localparam logic [25:0] W_FAULT = MFLT;

    function automatic logic [25:0] observe();
        return {bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.Rout,
                bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.MARin, bus.PCin,
                bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin,
                bus.IncPC, bus.Read, bus.run, bus.mem_fault, bus.alu_op};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        check_eq("drv_onehot",
                 32'($onehot0({bus.PCout, bus.Zhighout, bus.Zlowout, bus.MDRout, bus.Rout})), 32'd1);
        check_eq("gr_onehot", 32'($onehot0({bus.Gra, bus.Grb, bus.Grc})), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq(e.tag, 32'(observe()), 32'(e.word));
        end
    end

    task automatic push(input logic [25:0] w, input string t);
        exp_t e;
        e.word = w;
        e.tag  = t;
        sb.push_back(e);
    endtask

    // Everything from T2 onward, derived from the opcode class.
    task automatic push_exec(input logic [4:0] op, input string t);
        push(W_T2, {t, "_t2"});
        if (op == 5'b00011 || op == 5'b00100 || op == 5'b00101 || op == 5'b00110) begin
            push(W_A3, {t, "_t3"});
            push(W_A4 | {21'd0, op}, {t, "_t4"});
            push(W_A5, {t, "_t5"});
        end else if (op == 5'b01111 || op == 5'b10000) begin
            push(W_M3, {t, "_t3"});
            push(W_M4 | {21'd0, op}, {t, "_t4"});
            push(W_M5, {t, "_t5"});
            push(W_M6, {t, "_t6"});
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        #1;
    endtask

    // Leaves the FSM in RESET with clear released; next queued word is T0.
    task automatic do_reset();
        clear = 1'b1;
        push(W_RESET, "rst_hold");
        drain();
        clear = 1'b0;
        push(W_RESET, "rst_release");
    endtask

    initial begin
        logic [4:0] ops[4];
        logic [4:0] nops[3];
        ops  = '{OP_SUB, OP_AND, OP_OR, OP_DIV};
        nops = '{OP_NOP, 5'b11111, 5'b00000};

        clear         = 1'b0;
        bus.mem_ready = 1'b1;
        bus.ir_opcode = OP_ADD;
        #1 clear = 1'b1;
        @(posedge clock);
        #1;

        // ADD with memory ready immediately, back into the next fetch
        do_reset();
        push(W_T0, "add_t0");
        push(W_T1F, "add_t1");
        push_exec(OP_ADD, "add");
        push(W_T0, "add_next_t0");
        drain();

        foreach (ops[i]) begin
            bus.ir_opcode = ops[i];
            do_reset();
            push(W_T0, "op_t0");
            push(W_T1F, "op_t1");
            push_exec(ops[i], $sformatf("op%0d", i));
            push(W_T0, "op_next_t0");
            drain();
        end

        // MUL: next fetch on cycle 8
        bus.ir_opcode = OP_MUL;
        do_reset();
        push(W_T0, "mul_t0");
        push(W_T1F, "mul_t1");
        push_exec(OP_MUL, "mul");
        push(W_T0, "mul_next_t0");
        push(W_T1F, "mul_next_t1");
        drain();

        // Three wait cycles in T1
        bus.ir_opcode = OP_ADD;
        bus.mem_ready = 1'b0;
        do_reset();
        push(W_T0, "wait_t0");
        push(W_T1F, "wait_t1a");
        push(W_T1W, "wait_t1b");
        push(W_T1W, "wait_t1c");
        drain();
        bus.mem_ready = 1'b1;
        push(W_T1W, "wait_t1d");
        push_exec(OP_ADD, "wait");
        push(W_T0, "wait_next_t0");
        drain();

        // Ready arrives on the last cycle before timeout
        bus.mem_ready = 1'b0;
        do_reset();
        push(W_T0, "late_t0");
        push(W_T1F, "late_t1");
        for (int k = 0; k < 13; k++) push(W_T1W, "late_t1w");
        drain();
        bus.mem_ready = 1'b1;
        push(W_T1W, "late_t1_last");
        push_exec(OP_ADD, "late");
        drain();

        // Timeout into FAULT, absorbing, then recovery via clear
        bus.mem_ready = 1'b0;
        do_reset();
        push(W_T0, "tmo_t0");
        push(W_T1F, "tmo_t1");
        for (int k = 0; k < 14; k++) push(W_T1W, "tmo_t1w");
        for (int k = 0; k < 3; k++) push(W_FAULT, "tmo_fault");
        drain();
        bus.mem_ready = 1'b1;
        push(W_FAULT, "fault_hold");
        push(W_FAULT, "fault_hold");
        drain();
        do_reset();
        push(W_T0, "recov_t0");
        push(W_T1F, "recov_t1");
        push_exec(OP_ADD, "recov");
        drain();

        // HALT is absorbing regardless of later opcode
        bus.ir_opcode = OP_HALT;
        do_reset();
        push(W_T0, "halt_t0");
        push(W_T1F, "halt_t1");
        push_exec(OP_HALT, "halt");
        for (int k = 0; k < 5; k++) push(W_HALT, "halt_hold");
        drain();
        bus.ir_opcode = OP_ADD;
        push(W_HALT, "halt_stay");
        push(W_HALT, "halt_stay");
        drain();

        // NOP and unsupported opcodes return to fetch after T2
        foreach (nops[i]) begin
            bus.ir_opcode = nops[i];
            do_reset();
            push(W_T0, "nop_t0");
            push(W_T1F, "nop_t1");
            push_exec(nops[i], $sformatf("nop%0d", i));
            push(W_T0, "nop_next_t0");
            push(W_T1F, "nop_next_t1");
            drain();
        end

        // Asynchronous clear in the middle of T4 of an ADD
        bus.ir_opcode = OP_ADD;
        do_reset();
        push(W_T0, "clr_t0");
        push(W_T1F, "clr_t1");
        push(W_T2, "clr_t2");
        push(W_A3, "clr_t3");
        drain();
        push(W_A4 | 26'b00011, "clr_t4");
        #5;
        clear = 1'b1;
        #1;
        check_eq("clr_async", 32'(observe()), 32'(W_RESET));
        #1;
        clear = 1'b0;
        @(posedge clock);
        #1;
        push(W_T0, "clr_restart_t0");
        push(W_T1F, "clr_restart_t1");
        push_exec(OP_ADD, "clr_restart");
        push(W_T0, "clr_next_t0");
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
